// File: rtl/ad9361_tdd_seq.sv
// TDD switching sequencer for the AD9361 front end: drives ENABLE, TXNRX, PA enable and the
// T/R switch in a guard-timed order from CTRL register strobes or external frame-timer edges.
module ad9361_tdd_seq #(
    parameter logic [17:0] BASE  = 18'h200,
    parameter int          CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wen,
    input  logic [17:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        ext_tx,
    input  logic        ext_rx,
    output logic        ad9361_en,
    output logic        ad9361_tx_rx,
    output logic        pa_en,
    output logic        rf_sw,
    output logic        busy
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RX_EN = 4'd1,
        ST_RX_ON = 4'd2,
        ST_TX_SW = 4'd3,
        ST_TX_EN = 4'd4,
        ST_TX_PA = 4'd5,
        ST_TX_ON = 4'd6,
        ST_RX_PA = 4'd7,
        ST_RX_SW = 4'd8
    } state_t;

    localparam logic [17:0] A_CTRL   = BASE;
    localparam logic [17:0] A_SW     = BASE + 18'h4;
    localparam logic [17:0] A_EN     = BASE + 18'h8;
    localparam logic [17:0] A_PA     = BASE + 18'hC;
    localparam logic [17:0] A_STATUS = BASE + 18'h10;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] dly_r;
    logic [CNT_W-1:0] dly_sel_s;
    logic [CNT_W-1:0] sw_dly_r;
    logic [CNT_W-1:0] en_dly_r;
    logic [CNT_W-1:0] pa_dly_r;
    logic             trig_en_r;
    logic             ext_tx_d_r;
    logic             ext_rx_d_r;
    logic             err_r;
    logic             pend_v_r;
    logic [1:0]       pend_req_r;
    logic [4:0]       pins_nxt_s;
    logic [31:0]      rd_data_s;
    logic [31:0]      status_s;

    logic wr_s, rd_s, ctrl_wr_s;
    logic c_tx_s, c_rx_s, c_stop_s, c_clr_s, ctrl_cmd_s;
    logic e_tx_s, e_rx_s, req_tx_s, req_rx_s, conflict_s;
    logic fresh_tx_s, fresh_rx_s, eff_tx_s, eff_rx_s;
    logic steady_s, done_s, err_set_s;
    logic unused_s;

    assign wr_s      = en & wen;
    assign rd_s      = en & ~wen;
    assign ctrl_wr_s = wr_s & (addr == A_CTRL);
    assign c_tx_s    = ctrl_wr_s & din[0];
    assign c_rx_s    = ctrl_wr_s & din[1];
    assign c_stop_s  = ctrl_wr_s & din[3];
    assign c_clr_s   = ctrl_wr_s & din[7];
    assign ctrl_cmd_s = c_tx_s | c_rx_s | c_stop_s;

    // Any CTRL command in a cycle masks the external edges of that cycle.
    assign e_tx_s     = trig_en_r & ext_tx & ~ext_tx_d_r;
    assign e_rx_s     = trig_en_r & ext_rx & ~ext_rx_d_r;
    assign req_tx_s   = ctrl_cmd_s ? c_tx_s : e_tx_s;
    assign req_rx_s   = ctrl_cmd_s ? c_rx_s : e_rx_s;
    assign conflict_s = req_tx_s & req_rx_s;
    assign fresh_tx_s = req_tx_s & ~req_rx_s;
    assign fresh_rx_s = req_rx_s & ~req_tx_s;

    // A fresh request outranks the pending slot when both are seen in a steady state.
    assign eff_tx_s = fresh_tx_s | (~fresh_tx_s & ~fresh_rx_s & pend_v_r & pend_req_r[0]);
    assign eff_rx_s = fresh_rx_s | (~fresh_tx_s & ~fresh_rx_s & pend_v_r & pend_req_r[1]);

    assign steady_s  = (state_r == ST_IDLE) | (state_r == ST_RX_ON) | (state_r == ST_TX_ON);
    assign done_s    = (cnt_r == dly_r);
    assign err_set_s = conflict_s | (c_stop_s & ~((state_r == ST_IDLE) | (state_r == ST_RX_ON)));
    assign status_s  = {23'd0, pend_req_r, err_r, pend_v_r, busy, state_r};
    assign unused_s  = &{1'b0, din[31:CNT_W]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (eff_tx_s) begin
                    state_nxt_s = ST_TX_SW;
                end else if (eff_rx_s) begin
                    state_nxt_s = ST_RX_EN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RX_EN: state_nxt_s = done_s ? ST_RX_ON : ST_RX_EN;
            ST_RX_ON: begin
                if (c_stop_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (eff_tx_s) begin
                    state_nxt_s = ST_TX_SW;
                end else begin
                    state_nxt_s = ST_RX_ON;
                end
            end
            ST_TX_SW: state_nxt_s = done_s ? ST_TX_EN : ST_TX_SW;
            ST_TX_EN: state_nxt_s = done_s ? ST_TX_PA : ST_TX_EN;
            ST_TX_PA: state_nxt_s = done_s ? ST_TX_ON : ST_TX_PA;
            ST_TX_ON: state_nxt_s = eff_rx_s ? ST_RX_PA : ST_TX_ON;
            ST_RX_PA: state_nxt_s = done_s ? ST_RX_SW : ST_RX_PA;
            ST_RX_SW: state_nxt_s = done_s ? ST_RX_EN : ST_RX_SW;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode {en, tx_rx, pa, sw, busy} for the state being entered.
    always_comb begin
        pins_nxt_s = 5'b00000;
        case (state_nxt_s)
            ST_IDLE:  pins_nxt_s = 5'b00000;
            ST_RX_EN: pins_nxt_s = 5'b10001;
            ST_RX_ON: pins_nxt_s = 5'b10000;
            ST_TX_SW: pins_nxt_s = 5'b00011;
            ST_TX_EN: pins_nxt_s = 5'b11011;
            ST_TX_PA: pins_nxt_s = 5'b11111;
            ST_TX_ON: pins_nxt_s = 5'b11110;
            ST_RX_PA: pins_nxt_s = 5'b11011;
            ST_RX_SW: pins_nxt_s = 5'b00001;
            default:  pins_nxt_s = 5'b00000;
        endcase
    end

    // Registered pin outputs, so they change on the edge entering each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {ad9361_en, ad9361_tx_rx, pa_en, rf_sw, busy} <= 5'b00000;
        end else begin
            {ad9361_en, ad9361_tx_rx, pa_en, rf_sw, busy} <= pins_nxt_s;
        end
    end

    // Guard delay that applies to the state being entered.
    always_comb begin
        dly_sel_s = CNT_ZERO;
        case (state_nxt_s)
            ST_RX_EN, ST_TX_EN: dly_sel_s = en_dly_r;
            ST_TX_SW, ST_RX_SW: dly_sel_s = sw_dly_r;
            ST_TX_PA, ST_RX_PA: dly_sel_s = pa_dly_r;
            default:            dly_sel_s = CNT_ZERO;
        endcase
    end

    // Guard counter: delay is latched on entry so later writes do not disturb a running count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
            dly_r <= CNT_ZERO;
        end else if (state_nxt_s != state_r) begin
            cnt_r <= CNT_ZERO;
            dly_r <= dly_sel_s;
        end else if (!steady_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Delay registers, trigger enable and external edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_dly_r   <= CNT_ZERO;
            en_dly_r   <= CNT_ZERO;
            pa_dly_r   <= CNT_ZERO;
            trig_en_r  <= 1'b0;
            ext_tx_d_r <= 1'b0;
            ext_rx_d_r <= 1'b0;
        end else begin
            ext_tx_d_r <= ext_tx;
            ext_rx_d_r <= ext_rx;
            if (wr_s && (addr == A_SW)) sw_dly_r <= din[CNT_W-1:0];
            else                        sw_dly_r <= sw_dly_r;
            if (wr_s && (addr == A_EN)) en_dly_r <= din[CNT_W-1:0];
            else                        en_dly_r <= en_dly_r;
            if (wr_s && (addr == A_PA)) pa_dly_r <= din[CNT_W-1:0];
            else                        pa_dly_r <= pa_dly_r;
            if (ctrl_wr_s)              trig_en_r <= din[2];
            else                        trig_en_r <= trig_en_r;
        end
    end

    // Sticky error and the one-deep pending request slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r      <= 1'b0;
            pend_v_r   <= 1'b0;
            pend_req_r <= 2'b00;
        end else begin
            if (err_set_s)    err_r <= 1'b1;
            else if (c_clr_s) err_r <= 1'b0;
            else              err_r <= err_r;
            if (steady_s) begin
                pend_v_r   <= 1'b0;
                pend_req_r <= 2'b00;
            end else if (fresh_tx_s || fresh_rx_s) begin
                pend_v_r   <= 1'b1;
                pend_req_r <= {fresh_rx_s, fresh_tx_s};
            end else begin
                pend_v_r   <= pend_v_r;
                pend_req_r <= pend_req_r;
            end
        end
    end

    // Read mux.
    always_comb begin
        rd_data_s = 32'd0;
        case (addr)
            A_SW:     rd_data_s = {{(32-CNT_W){1'b0}}, sw_dly_r};
            A_EN:     rd_data_s = {{(32-CNT_W){1'b0}}, en_dly_r};
            A_PA:     rd_data_s = {{(32-CNT_W){1'b0}}, pa_dly_r};
            A_STATUS: rd_data_s = status_s;
            default:  rd_data_s = 32'd0;
        endcase
    end

    // Registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= 32'd0;
        end else if (rd_s) begin
            dout <= rd_data_s;
        end else begin
            dout <= dout;
        end
    end

endmodule

// File: tb/tb_ad9361_tdd_seq.sv
// Bench for ad9361_tdd_seq: directed scenarios with literal expectations, then randomized
// bus/ext traffic compared every cycle against a countdown-based behavioural model.
module tb_ad9361_tdd_seq;

    localparam logic [17:0] BASE   = 18'h200;
    localparam logic [17:0] A_CTRL = BASE;
    localparam logic [17:0] A_SW   = BASE + 18'h4;
    localparam logic [17:0] A_EN   = BASE + 18'h8;
    localparam logic [17:0] A_PA   = BASE + 18'hC;
    localparam logic [17:0] A_ST   = BASE + 18'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        wen = 1'b0;
    logic [17:0] addr = 18'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] dout;
    logic        ext_tx = 1'b0;
    logic        ext_rx = 1'b0;
    logic        ad9361_en, ad9361_tx_rx, pa_en, rf_sw, busy;

    int checks = 0;
    int failures = 0;

    ad9361_tdd_seq #(.BASE(BASE), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr), .din(din), .dout(dout),
        .ext_tx(ext_tx), .ext_rx(ext_rx), .ad9361_en(ad9361_en), .ad9361_tx_rx(ad9361_tx_rx),
        .pa_en(pa_en), .rf_sw(rf_sw), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: states by STATUS code, pins/busy/successor/delay by table lookup.
    logic [3:0] pins_t [0:8] = '{4'b0000, 4'b1000, 4'b1000, 4'b0001, 4'b1101,
                                 4'b1111, 4'b1111, 4'b1101, 4'b0000};
    int busy_t [0:8] = '{0, 1, 0, 1, 1, 1, 0, 1, 1};
    int succ_t [0:8] = '{0, 2, 2, 4, 5, 6, 6, 8, 1};
    int didx_t [0:8] = '{-1, 1, -1, 0, 1, 2, -1, 2, 0};

    int m_state = 0, m_left = 0, m_pv = 0, m_pr = 0, m_err = 0, m_trig = 0;
    int m_ptx = 0, m_prx = 0, m_dchk = 0;
    int m_dly [0:2] = '{0, 0, 0};
    logic [31:0] m_dexp = 32'd0;

    int tally_c [0:15];
    int tally_viol;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int cw, ctx, crx, cstp, cclr, rtx, rrx, req, eff, nxt, set_err;
        if (rst) begin
            m_state = 0; m_left = 0; m_pv = 0; m_pr = 0; m_err = 0; m_trig = 0;
            m_ptx = 0; m_prx = 0; m_dchk = 0; m_dexp = 32'd0;
            m_dly[0] = 0; m_dly[1] = 0; m_dly[2] = 0;
            return;
        end
        cw   = (en && wen && addr == A_CTRL) ? 1 : 0;
        ctx  = cw & int'(din[0]);
        crx  = cw & int'(din[1]);
        cstp = cw & int'(din[3]);
        cclr = cw & int'(din[7]);
        if (ctx != 0 || crx != 0 || cstp != 0) begin
            rtx = ctx; rrx = crx;
        end else begin
            rtx = (m_trig != 0 && ext_tx && m_ptx == 0) ? 1 : 0;
            rrx = (m_trig != 0 && ext_rx && m_prx == 0) ? 1 : 0;
        end
        set_err = rtx & rrx;
        req = (set_err != 0) ? 0 : (rtx != 0) ? 1 : (rrx != 0) ? 2 : 0;
        m_dchk = (en && !wen) ? 1 : 0;
        if (m_dchk != 0) begin
            if (addr == A_SW)      m_dexp = m_dly[0];
            else if (addr == A_EN) m_dexp = m_dly[1];
            else if (addr == A_PA) m_dexp = m_dly[2];
            else if (addr == A_ST) m_dexp = m_state + 16 * busy_t[m_state] + 32 * m_pv + 64 * m_err + 128 * m_pr;
            else                   m_dexp = 32'd0;
        end
        nxt = m_state;
        if (busy_t[m_state] == 0) begin
            eff = req;
            if (eff == 0 && m_pv != 0) eff = m_pr;
            m_pv = 0; m_pr = 0;
            if (cstp != 0 && m_state == 2) nxt = 0;
            else begin
                if (cstp != 0 && m_state == 6) set_err = 1;
                if (eff == 1 && m_state != 6) nxt = 3;
                if (eff == 2 && m_state != 2) nxt = (m_state == 6) ? 7 : 1;
            end
        end else begin
            if (cstp != 0) set_err = 1;
            if (req != 0) begin m_pv = 1; m_pr = req; end
            if (m_left == 0) nxt = succ_t[m_state];
            else m_left = m_left - 1;
        end
        if (nxt != m_state) begin
            m_state = nxt;
            if (didx_t[nxt] >= 0) m_left = m_dly[didx_t[nxt]];
        end
        if (set_err != 0)   m_err = 1;
        else if (cclr != 0) m_err = 0;
        if (cw != 0) m_trig = int'(din[2]);
        if (en && wen && addr == A_SW) m_dly[0] = int'(din[15:0]);
        if (en && wen && addr == A_EN) m_dly[1] = int'(din[15:0]);
        if (en && wen && addr == A_PA) m_dly[2] = int'(din[15:0]);
        m_ptx = int'(ext_tx);
        m_prx = int'(ext_rx);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("pins", {28'd0, ad9361_en, ad9361_tx_rx, pa_en, rf_sw}, {28'd0, pins_t[m_state]});
        check("busy", {31'd0, busy}, 32'(busy_t[m_state]));
        if (m_dchk != 0) check("dout", dout, m_dexp);
    end

    task automatic bus_write(input logic [17:0] a, input logic [31:0] d);
        en = 1'b1; wen = 1'b1; addr = a; din = d;
        @(negedge clk);
        en = 1'b0; wen = 1'b0;
    endtask

    task automatic bus_read(input logic [17:0] a, output logic [31:0] d);
        en = 1'b1; wen = 1'b0; addr = a;
        @(negedge clk);
        en = 1'b0;
        d = dout;
    endtask

    task automatic tally_seq();
        for (int i = 0; i < 16; i++) tally_c[i] = 0;
        tally_viol = 0;
        for (int k = 0; k < 64; k++) begin
            if (!busy) return;
            tally_c[{ad9361_en, ad9361_tx_rx, pa_en, rf_sw}]++;
            if (pa_en && !rf_sw) tally_viol++;
            @(negedge clk);
        end
        checks++; failures++;
        $display("FAIL seq_timeout: busy got 1 expected 0 within 64 cycles");
    endtask

    logic [31:0] rd;
    logic [31:0] v;
    int r;
    int found;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_pins", {27'd0, ad9361_en, ad9361_tx_rx, pa_en, rf_sw, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        bus_read(A_ST, rd);
        check("reset_status", rd, 32'h0);

        bus_write(A_SW, 32'd2);
        bus_write(A_EN, 32'd3);
        bus_write(A_PA, 32'd4);
        bus_read(A_PA, rd);
        check("pa_dly_read", rd, 32'd4);
        bus_write(A_CTRL, 32'h2);
        check("rx_en_rise", {31'd0, ad9361_en}, 32'd1);
        repeat (3) @(negedge clk);
        check("rx_en_4th_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("rx_on_busy", {31'd0, busy}, 32'd0);
        bus_read(A_ST, rd);
        check("rx_on_status", rd, 32'h2);

        bus_write(A_CTRL, 32'h1);
        tally_seq();
        check("tx_sw_cycles", 32'(tally_c[4'b0001]), 32'd3);
        check("tx_en_cycles", 32'(tally_c[4'b1101]), 32'd4);
        check("tx_pa_cycles", 32'(tally_c[4'b1111]), 32'd5);
        bus_read(A_ST, rd);
        check("tx_on_status", rd, 32'h6);

        bus_write(A_CTRL, 32'h2);
        tally_seq();
        check("rx_pa_cycles", 32'(tally_c[4'b1101]), 32'd5);
        check("rx_sw_cycles", 32'(tally_c[4'b0000]), 32'd3);
        check("rx_en_cycles", 32'(tally_c[4'b1000]), 32'd4);
        check("pa_without_sw", 32'(tally_viol), 32'd0);

        bus_write(A_CTRL, 32'h1);
        bus_write(A_CTRL, 32'h2);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_ST, rd);
        check("pending_status", rd, 32'hB3);
        tally_seq();
        @(negedge clk);
        bus_read(A_ST, rd);
        check("pending_consumed", rd, 32'h6);

        bus_write(A_CTRL, 32'h2);
        tally_seq();
        bus_write(A_CTRL, 32'h4);
        ext_tx = 1'b1;
        bus_write(A_CTRL, 32'h6);
        check("ctrl_wins_busy", {31'd0, busy}, 32'd0);
        ext_tx = 1'b0;
        @(negedge clk);
        ext_tx = 1'b1;
        @(negedge clk);
        check("ext_tx_seq", {30'd0, rf_sw, busy}, 32'd3);
        tally_seq();

        bus_write(A_CTRL, 32'h3);
        bus_read(A_ST, rd);
        check("conflict_err", rd, 32'h46);
        bus_write(A_CTRL, 32'h8);
        bus_read(A_ST, rd);
        check("stop_tx_on", rd, 32'h46);
        bus_write(A_CTRL, 32'h80);
        bus_read(A_ST, rd);
        check("err_clr", rd, 32'h06);

        ext_tx = 1'b0;
        bus_write(A_CTRL, 32'h2);
        tally_seq();
        bus_write(A_CTRL, 32'h1);
        found = 0;
        for (int k = 0; k < 64 && found == 0; k++) begin
            if (pa_en && busy) found = 1;
            else @(negedge clk);
        end
        check("reach_tx_pa", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1 check("async_reset", {27'd0, ad9361_en, ad9361_tx_rx, pa_en, rf_sw, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic; delays kept small so many sequences complete.
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            en = 1'b0; wen = 1'b0;
            if (r < 10) begin
                v = 32'd0;
                case ($urandom_range(0, 5))
                    0: v[0] = 1'b1;
                    1: v[1] = 1'b1;
                    2: v[3] = 1'b1;
                    3: v[7] = 1'b1;
                    4: v[1:0] = 2'b11;
                    default: v[0] = 1'b1;
                endcase
                v[2] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) v[7] = 1'b1;
                en = 1'b1; wen = 1'b1; addr = A_CTRL; din = v;
            end else if (r < 16) begin
                case ($urandom_range(0, 2))
                    0: addr = A_SW;
                    1: addr = A_EN;
                    default: addr = A_PA;
                endcase
                en = 1'b1; wen = 1'b1;
                din = {16'($urandom), 16'($urandom_range(0, 4))};
            end else if (r < 28) begin
                case ($urandom_range(0, 6))
                    0: addr = A_CTRL;
                    1: addr = A_SW;
                    2: addr = A_EN;
                    3: addr = A_PA;
                    4: addr = A_ST;
                    5: addr = A_ST + 18'h4;
                    default: addr = 18'($urandom);
                endcase
                en = 1'b1; wen = 1'b0;
            end else if (r < 31) begin
                en = 1'b1; wen = 1'b1;
                addr = ($urandom_range(0, 1) == 0) ? A_ST : 18'($urandom);
                din = $urandom;
            end
            if ($urandom_range(0, 9) == 0) ext_tx = ~ext_tx;
            if ($urandom_range(0, 9) == 0) ext_rx = ~ext_rx;
            @(negedge clk);
        end
        en = 1'b0; wen = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ad9361_tdd_seq.md
Name: ad9361_tdd_seq

Overview:
- Register-mapped TDD switching sequencer for the AD9361 front end.
- Drives ENABLE, TXNRX, PA enable and the T/R antenna switch in a fixed, guard-timed order, so software or an external frame timer can request TX or RX with one command.
- Sits on the same 18-bit register bus as the other AD9361 control blocks and replaces direct software toggling of these pins.

Parameters:
- BASE, 18'h200, register block base address.
- CNT_W, 16, width of the guard-delay counters and delay registers.

Ports:
- clk  input  1  register-bus and sequencer clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  bus access strobe.
- wen  input  1  write enable; qualified by en.
- addr  input  18  bus byte address.
- din  input  32  write data.
- dout  output  32  read data, registered.
- ext_tx  input  1  external TX request, level, synchronous to clk.
- ext_rx  input  1  external RX request, level, synchronous to clk.
- ad9361_en  output  1  AD9361 ENABLE pin.
- ad9361_tx_rx  output  1  AD9361 TXNRX pin; 1 = TX.
- pa_en  output  1  PA enable.
- rf_sw  output  1  T/R switch; 1 = TX path.
- busy  output  1  high in any transition state.

Behaviour:
Reset and clock:
- Reset: rst asynchronous, active-high; clock clk.
- On reset: all outputs 0, state IDLE, delay registers 0, pending/err/ext_trig_en cleared, dout 0.

Registers (byte offsets from BASE):
- +0x00 CTRL, write-only.
  - bit0 go_tx, bit1 go_rx, bit3 stop, bit7 err_clr: self-clearing command strobes.
  - bit2 ext_trig_en: stored.
- +0x04 SW_DLY[CNT_W-1:0]: switch settle time.
- +0x08 EN_DLY: ENABLE settle time.
- +0x0C PA_DLY: PA on/off time.
- +0x10 STATUS, read-only:
  - [3:0] state, [4] busy, [5] pending valid, [6] err sticky, [8:7] pending request (01 TX, 10 RX).
- Write: en & wen & address match; unmatched addresses ignored.
- Read: en & !wen → dout valid next cycle. Delay registers read back zero-extended, CTRL reads 0, unmapped addresses read 0.

States (STATUS encoding) and outputs en/tx_rx/pa/sw:
- 0 IDLE 0/0/0/0.
- 1 RX_EN 1/0/0/0.
- 2 RX_ON 1/0/0/0.
- 3 TX_SW 0/0/0/1.
- 4 TX_EN 1/1/0/1.
- 5 TX_PA 1/1/1/1.
- 6 TX_ON 1/1/1/1.
- 7 RX_PA 1/1/0/1.
- 8 RX_SW 0/0/0/0.

Outputs are registered and change on the clock edge that enters the state.

Transitions:
- IDLE: go_rx → RX_EN; go_tx → TX_SW.
- RX_EN → RX_ON after EN_DLY.
- RX_ON: go_tx → TX_SW; stop → IDLE.
- TX_SW → TX_EN after SW_DLY.
- TX_EN → TX_PA after EN_DLY.
- TX_PA → TX_ON after PA_DLY.
- TX_ON: go_rx → RX_PA.
- RX_PA → RX_SW after PA_DLY.
- RX_SW → RX_EN after SW_DLY.

Timed states:
- A timed state lasts DLY+1 cycles; DLY=0 gives 1 cycle.
- The counter loads 0 on state entry and advances when count == DLY.
- Delay values are sampled on entry; writes during a state do not affect the running count.

Requests:
- Sources: CTRL strobes, and rising edges of ext_tx/ext_rx when ext_trig_en=1. Edge detection uses a registered previous value, which resets to 0.
- CTRL and ext in the same cycle: CTRL wins.
- go_tx and go_rx in the same cycle: both dropped, err set.
- Request while busy: stored in a one-deep pending slot, newest overwrites. It is consumed on the first cycle in RX_ON/TX_ON and acted on only if it differs from the current steady direction.
- Request matching the current steady state (go_tx in TX_ON, go_rx in RX_ON/RX_EN path): no-op.
- stop outside RX_ON/IDLE: ignored, err set. stop in IDLE: no-op.
- err is sticky; cleared by err_clr. err set and err_clr in the same cycle: set wins.
- Reset mid-sequence: all outputs drop to 0 asynchronously.

Test Plan:
- Reset, then read STATUS → 0x0. Write SW=2, EN=3, PA=4, go_rx → ad9361_en rises 1 cycle after write, state 2 after 4 cycles in RX_EN.
- From RX_ON issue go_tx → rf_sw=1 and en=0 for 3 cycles; then en=1/tx_rx=1 for 4 cycles; pa_en=1 4 cycles after that; state 6, busy low.
- From TX_ON issue go_rx → pa_en=0 first for 5 cycles, then en/tx_rx/rf_sw=0 for 3 cycles, then RX_EN; pa_en never high while rf_sw=0.
- Issue go_rx then go_tx during TX_SW → STATUS[8:7]=01 (go_tx overwrote go_rx), pending consumed on reaching TX_ON, no extra sequence.
- ext_trig_en=1, pulse ext_tx while in RX_ON with a simultaneous CTRL go_rx → CTRL wins: no-op. Next ext_tx edge → TX sequence.
- Write CTRL=0x3 → err=1, no state change. stop in TX_ON → err stays 1. err_clr → STATUS[6]=0. Assert rst in TX_PA → all outputs 0 immediately.
